// File: rtl/image_stream_source.sv
// Self-timed source of the typed image stream: frame/header/row markers,
// test-pattern pixels and programmable horizontal/vertical blanking.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd3
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd4
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd5
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd6
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd7
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd8
`endif
`ifndef Image_num_cols
`define Image_num_cols 0
`endif
`ifndef Image_num_rows
`define Image_num_rows 1
`endif

module image_stream_source #(
    parameter int PIXEL_WIDTH    = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_COLS_WIDTH = 11,
    parameter int NUM_ROWS_WIDTH = 11,
    parameter int HEADER_LEN     = 32,
    parameter int FC_ADDR        = 2,
    parameter logic [`DTYPE_WIDTH-1:0] PIXEL_DTYPE = `DTYPE_PIXEL
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_COLS_WIDTH-1:0] num_cols,
    input  logic [NUM_ROWS_WIDTH-1:0] num_rows,
    input  logic [15:0]               hblank,
    input  logic [15:0]               vblank,
    input  logic [1:0]                mode,
    input  logic [PIXEL_WIDTH-1:0]    const_value,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [DATA_WIDTH-1:0]     datao,
    output logic [15:0]               frame_count,
    output logic                      busy
);

    localparam int IW = (HEADER_LEN > 1) ? $clog2(HEADER_LEN) : 1;
    localparam int CW = NUM_COLS_WIDTH;
    localparam int RW = NUM_ROWS_WIDTH;
    localparam logic [CW-1:0] COL_ONE = 1;
    localparam logic [RW-1:0] ROW_ONE = 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(HEADER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, FSTART, HSTART, HDR, HEND, RSTART,
        PIX, REND, HBLANK, FEND, VBLANK
    } state_t;

    state_t state, ns;

    logic [CW-1:0]          cols_q, col, n_col;
    logic [RW-1:0]          rows_q, row, n_row;
    logic [15:0]            hb_q, vb_q, blk, n_blk;
    logic [1:0]             mode_q;
    logic [PIXEL_WIDTH-1:0] cv_q, pix_cnt, px;
    logic [IW-1:0]          idx, n_idx;
    logic                   last_row;

    logic                    n_dv, n_busy;
    logic [`DTYPE_WIDTH-1:0] n_dt;
    logic [DATA_WIDTH-1:0]   n_da;

    assign last_row = (row == rows_q - ROW_ONE);

    always_comb begin
        ns    = state;
        n_idx = idx;
        n_col = col;
        n_row = row;
        n_blk = blk;
        unique case (state)
            IDLE:   if (enable) ns = FSTART;
            FSTART: ns = HSTART;
            HSTART: begin
                ns    = HDR;
                n_idx = '0;
            end
            HDR: begin
                if (idx == IDX_LAST) ns = HEND;
                else n_idx = idx + IW'(1);
            end
            HEND: begin
                if (rows_q == '0) ns = FEND;
                else begin
                    ns    = RSTART;
                    n_row = '0;
                end
            end
            RSTART: begin
                if (cols_q == '0) ns = REND;
                else begin
                    ns    = PIX;
                    n_col = '0;
                end
            end
            PIX: begin
                if (col == cols_q - COL_ONE) ns = REND;
                else n_col = col + COL_ONE;
            end
            REND: begin
                if (hb_q != '0) begin
                    ns    = HBLANK;
                    n_blk = 16'd1;
                end else if (last_row) ns = FEND;
                else begin
                    ns    = RSTART;
                    n_row = row + ROW_ONE;
                end
            end
            HBLANK: begin
                if (blk != hb_q) n_blk = blk + 16'd1;
                else if (last_row) ns = FEND;
                else begin
                    ns    = RSTART;
                    n_row = row + ROW_ONE;
                end
            end
            FEND: begin
                if (vb_q != '0) begin
                    ns    = VBLANK;
                    n_blk = 16'd1;
                end else ns = enable ? FSTART : IDLE;
            end
            VBLANK: begin
                if (blk != vb_q) n_blk = blk + 16'd1;
                else ns = enable ? FSTART : IDLE;
            end
            default: ns = IDLE;
        endcase
    end

    // Pixel pattern for the word being loaded into the output register
    always_comb begin
        px = '0;
        unique case (mode_q)
            2'd0: px = PIXEL_WIDTH'(n_col + n_row);
            2'd1: px = cv_q;
            2'd2: px = pix_cnt;
            default: px = (n_col[3] ^ n_row[3]) ? '1 : '0;
        endcase
    end

    always_comb begin
        n_dv   = 1'b1;
        n_dt   = '0;
        n_da   = '0;
        n_busy = (ns != IDLE);
        unique case (ns)
            FSTART: n_dt = `DTYPE_FRAME_START;
            HSTART: n_dt = `DTYPE_HEADER_START;
            HDR: begin
                n_dt = `DTYPE_HEADER;
                if (int'(n_idx) == `Image_num_cols)
                    n_da = DATA_WIDTH'(cols_q);
                else if (int'(n_idx) == `Image_num_rows)
                    n_da = DATA_WIDTH'(rows_q);
                else if (int'(n_idx) == FC_ADDR)
                    n_da = DATA_WIDTH'(frame_count);
            end
            HEND:   n_dt = `DTYPE_HEADER_END;
            RSTART: n_dt = `DTYPE_ROW_START;
            PIX: begin
                n_dt = PIXEL_DTYPE;
                n_da = DATA_WIDTH'(px);
            end
            REND:   n_dt = `DTYPE_ROW_END;
            FEND:   n_dt = `DTYPE_FRAME_END;
            default: n_dv = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            col         <= '0;
            row         <= '0;
            blk         <= '0;
            pix_cnt     <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            hb_q        <= '0;
            vb_q        <= '0;
            mode_q      <= '0;
            cv_q        <= '0;
            dvo         <= 1'b0;
            dtypeo      <= '0;
            datao       <= '0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            state  <= ns;
            idx    <= n_idx;
            col    <= n_col;
            row    <= n_row;
            blk    <= n_blk;
            dvo    <= n_dv;
            dtypeo <= n_dt;
            datao  <= n_da;
            busy   <= n_busy;
            if (ns == FSTART) begin
                cols_q  <= num_cols;
                rows_q  <= num_rows;
                hb_q    <= hblank;
                vb_q    <= vblank;
                mode_q  <= mode;
                cv_q    <= const_value;
                pix_cnt <= '0;
            end else if (ns == PIX) begin
                pix_cnt <= pix_cnt + PIXEL_WIDTH'(1);
            end
            if (ns == FEND) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: doc/image_stream_source.md
Name: image_stream_source

Overview:
- Self-timed transmitter of the team's typed image stream (dvo/dtypeo/datao).
- Generates complete frames: frame markers, header block, row markers, pixels, and blanking.
- Drives kernel, filter and downstream pipeline blocks on-chip and in benches without a sensor.
- Header carries `Image_num_cols and `Image_num_rows so receivers can parse and adjust geometry.

Parameters:
- PIXEL_WIDTH, 10, pixel bits; zero-extended into datao.
- DATA_WIDTH, 16, stream data width.
- NUM_COLS_WIDTH, 11, width of the column count and column counter.
- NUM_ROWS_WIDTH, 11, width of the row count and row counter.
- HEADER_LEN, 32, number of DTYPE_HEADER words per frame (1..64).
- FC_ADDR, 2, header index that carries frame_count.
- PIXEL_DTYPE, `DTYPE_PIXEL, dtype emitted on pixel words.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run frames; sampled at frame boundaries only.
- num_cols  input  NUM_COLS_WIDTH  pixels per row; latched at FRAME_START.
- num_rows  input  NUM_ROWS_WIDTH  rows per frame; latched at FRAME_START.
- hblank  input  16  idle cycles after each ROW_END; latched at FRAME_START.
- vblank  input  16  idle cycles after FRAME_END; latched at FRAME_START.
- mode  input  2  pattern select: 0 ramp, 1 constant, 2 counter, 3 checker; latched at FRAME_START.
- const_value  input  PIXEL_WIDTH  pixel value in mode 1; latched at FRAME_START.
- dvo  output  1  stream data valid.
- dtypeo  output  `DTYPE_WIDTH  stream word type.
- datao  output  DATA_WIDTH  stream data.
- frame_count  output  16  completed frames; increments at FRAME_END and wraps.
- busy  output  1  high from FRAME_START through the final vblank cycle.

Behaviour:
- All outputs are registered. Reset values: dvo=0, dtypeo=0, datao=0, frame_count=0, busy=0, FSM in IDLE. Reset mid-frame aborts immediately; no FRAME_END is emitted.
- FSM states: IDLE, FSTART, HSTART, HDR, HEND, RSTART, PIX, REND, HBLANK, FEND, VBLANK.
- IDLE: if enable=1 go to FSTART. The first stream word appears on the cycle after enable is sampled high.
- Every non-blank state emits exactly one dvo=1 word per cycle. Data is 0 except on HDR and PIX words.
- Word order per frame:
  - FRAME_START, HEADER_START.
  - HEADER ×HEADER_LEN, indexed i=0..HEADER_LEN-1.
  - HEADER_END.
  - For each row r=0..num_rows-1: ROW_START; PIXEL_DTYPE ×num_cols with c=0..num_cols-1; ROW_END; then hblank cycles with dvo=0.
  - FRAME_END, then vblank cycles with dvo=0.
- After VBLANK: if enable=1 go to FSTART, else IDLE. Deasserting enable mid-frame completes the current frame, including vblank.
- Header word i, first match wins:
  - i==`Image_num_cols: num_cols.
  - i==`Image_num_rows: num_rows.
  - i==FC_ADDR: frame_count.
  - otherwise 0.
  - Values are zero-extended to DATA_WIDTH. frame_count is the value before this frame's increment.
- Pixel value, truncated to PIXEL_WIDTH and zero-extended:
  - Mode 0: c+r.
  - Mode 1: const_value.
  - Mode 2: running pixel index within the frame, cleared at FRAME_START, wraps.
  - Mode 3: all ones if (c^r)[3], else 0.
- Boundary conditions:
  - num_rows=0: no rows; HEADER_END is followed directly by FRAME_END.
  - num_cols=0: ROW_START is immediately followed by ROW_END.
  - hblank=0: the next ROW_START (or FRAME_END) follows ROW_END on the next cycle. The last row still takes hblank before FRAME_END.
  - vblank=0 with enable=1: FRAME_START follows FRAME_END on the next cycle.
  - Input changes mid-frame have no effect until the next FRAME_START.
- frame_count increments on the cycle FRAME_END is emitted. 0xFFFF wraps to 0.

Test Plan:
- Basic frame: reset, num_cols=4, num_rows=3, hblank=2, vblank=5, mode=0, enable=1 → FRAME_START one cycle after enable. Pixel payloads 0,1,2,3 / 1,2,3,4 / 2,3,4,5. Exactly 2 dvo=0 cycles after each ROW_END. Total dvo=1 words = 2+HEADER_LEN+1+3×6+1 = 54. frame_count=1.
- Header: mode=1, const_value=0x155, run two frames → header index `Image_num_cols=4, `Image_num_rows=3, FC_ADDR=0 then 1, other indices 0. All pixels=0x155. Feed into kernel (KERNEL_SIZE=3) → kernel emits 2×1 kernels and header 2/1.
- Degenerate sizes: num_rows=0 → FRAME_START, HEADER_START, headers, HEADER_END, FRAME_END. num_cols=0,num_rows=2 → ROW_START/ROW_END pairs with no pixels.
- Enable and config timing: drop enable mid-row of frame 0 and change num_cols there → frame 0 completes unchanged, vblank honoured, then IDLE with busy=0. Re-enable → new num_cols used.
- Reset mid-PIX state → next cycle dvo=0, frame_count=0, busy=0. Restart yields a clean FRAME_START.
- Modes 2/3, num_cols=20, num_rows=2, PIXEL_WIDTH=10: mode 2 → pixels 0..39. Mode 3 → row 0: c 8..15 = 0x3FF, others 0.
